// File: rtl/pipes_pkg.sv
// pipes: shared pipeline types and helpers
// stage payload structs plus elastic buffer sizing
package pipes;

  typedef logic u1;

  parameter int PIPE_BUF_DEPTH_DEFAULT = 2;

  typedef struct packed {
    u1 valid;
    u1 ready;
  } handshake_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_data_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } decode_data_t;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pipe_wrap_ctr.sv
// pipe_wrap_ctr: modulo-MAX pointer counter
// explicit wrap so non-power-of-2 MAX works
module pipe_wrap_ctr
  import pipes::*;
#(
  parameter  int MAX = 2,
  localparam int W   = ptr_w(MAX)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] value
);

  // clear has priority; wrap at MAX-1 by compare
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      value <= '0;
    end else if (inc) begin
      value <= (value == W'(MAX - 1)) ? '0 : value + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: elastic valid/ready stage buffer
// DEPTH-entry ring with flush and occupancy count
module pipe_stage_buf
  import pipes::*;
#(
  parameter  int WIDTH        = 64,
  parameter  int DEPTH        = PIPE_BUF_DEPTH_DEFAULT,
  parameter  bit READY_ON_POP = 1'b1,
  parameter  bit ZERO_EMPTY   = 1'b1,
  localparam int CW           = cnt_w(DEPTH),
  localparam int PW           = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    hptr;
  logic [PW-1:0]    tptr;
  logic [CW-1:0]    cnt;
  handshake_t       hs_in;
  handshake_t       hs_out;
  logic             push;
  logic             pop;
  logic             room;

  assign room      = (cnt < CW'(DEPTH));
  assign in_ready  = room | (READY_ON_POP & out_ready);
  assign out_valid = (cnt != '0);
  assign count     = cnt;

  assign hs_in  = '{valid: in_valid, ready: in_ready};
  assign hs_out = '{valid: out_valid, ready: out_ready};
  assign push   = hs_in.valid & hs_in.ready;
  assign pop    = hs_out.valid & hs_out.ready;

  assign out_data = (ZERO_EMPTY && !out_valid) ? '0 : mem[hptr];

  // write the tail slot; squashed pushes never land
  always_ff @(posedge clk) begin
    if (push && !flush && !reset) begin
      mem[tptr] <= in_data;
    end
  end

  // occupancy: push and pop together cancel
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      cnt <= '0;
    end else if (push && !pop) begin
      cnt <= cnt + CW'(1);
    end else if (pop && !push) begin
      cnt <= cnt - CW'(1);
    end
  end

  pipe_wrap_ctr #(.MAX(DEPTH)) u_tptr (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .inc   (push),
    .value (tptr)
  );

  pipe_wrap_ctr #(.MAX(DEPTH)) u_hptr (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .inc   (pop),
    .value (hptr)
  );

`ifndef SYNTHESIS
  a_cnt_max: assert property (
    @(posedge clk) disable iff (reset)
    cnt <= CW'(DEPTH));

  a_no_over: assert property (
    @(posedge clk) disable iff (reset)
    !(push && !pop && cnt == CW'(DEPTH)));

  a_hold: assert property (
    @(posedge clk) disable iff (reset)
    (in_valid && !in_ready && !flush) |=> $stable(in_data))
    else $warning("in_data changed while stalled");
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: vectors plus queue model
// three configs: D2/no-pop-through, D2/pop-through, D3
module tb_pipe_stage_buf;

  logic            clk = 1'b0;
  logic            reset;
  logic            flush;
  logic [2:0]      iv;
  logic [2:0]      ordy;
  logic [2:0]      ov;
  logic [2:0]      ird;
  logic [2:0][7:0] id;
  logic [2:0][7:0] od;
  logic [2:0][1:0] oc;

  int n_chk  = 0;
  int n_fail = 0;

  typedef logic [7:0] q_t[$];
  q_t mq[3];
  q_t popped[3];
  int dep[3]  = '{2, 2, 3};
  bit rop[3]  = '{1'b0, 1'b1, 1'b1};
  bit hold[3] = '{1'b0, 1'b0, 1'b0};
  bit acc[3]  = '{1'b0, 1'b0, 1'b0};

  always #5 clk = ~clk;

  pipe_stage_buf #(.WIDTH(8), .DEPTH(2), .READY_ON_POP(1'b0), .ZERO_EMPTY(1'b1)) u0 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(iv[0]), .in_ready(ird[0]), .in_data(id[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .count(oc[0]));

  pipe_stage_buf #(.WIDTH(8), .DEPTH(2), .READY_ON_POP(1'b1), .ZERO_EMPTY(1'b1)) u1 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(iv[1]), .in_ready(ird[1]), .in_data(id[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .count(oc[1]));

  pipe_stage_buf #(.WIDTH(8), .DEPTH(3), .READY_ON_POP(1'b1), .ZERO_EMPTY(1'b1)) u2 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(iv[2]), .in_ready(ird[2]), .in_data(id[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]), .count(oc[2]));

  task automatic cmp(input string nm, input int i,
                     input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[u%0d]: got %0h expected %0h", nm, i, act, exp);
    end
  endtask

  function automatic bit mrdy(input int i);
    return (mq[i].size() < dep[i]) || (rop[i] && ordy[i]);
  endfunction

  // inputs already driven at negedge; check, then advance model at posedge
  task automatic cycle(input bit chk);
    bit psh[3];
    bit pp[3];
    #1;
    for (int i = 0; i < 3; i++) begin
      if (chk) begin
        cmp("valid", i, ov[i], mq[i].size() != 0);
        cmp("count", i, oc[i], mq[i].size());
        cmp("ready", i, ird[i], mrdy(i));
        cmp("data", i, od[i], (mq[i].size() != 0) ? mq[i][0] : 8'h00);
      end
      psh[i]  = iv[i] && mrdy(i);
      pp[i]   = ordy[i] && (mq[i].size() != 0);
      hold[i] = iv[i] && !mrdy(i) && !flush && !reset;
      acc[i]  = psh[i] && !flush && !reset;
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        mq[i].delete();
      end else begin
        if (pp[i]) popped[i].push_back(mq[i].pop_front());
        if (flush) mq[i].delete();
        else if (psh[i]) mq[i].push_back(id[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic drive(input bit r, input bit f, input bit v,
                       input logic [7:0] d, input bit o);
    reset = r;
    flush = f;
    for (int i = 0; i < 3; i++) begin
      iv[i]   = v;
      id[i]   = d;
      ordy[i] = o;
    end
  endtask

  typedef struct {
    bit         rst;
    bit         fl;
    bit         v;
    logic [7:0] d;
    bit         o;
    bit         chk;
    bit         ev;
    int         ec;
    bit         er;
    logic [7:0] ed;
  } vec_t;

  function automatic vec_t mk(input bit rst, input bit fl, input bit v,
                              input logic [7:0] d, input bit o, input bit chk,
                              input bit ev, input int ec, input bit er,
                              input logic [7:0] ed);
    vec_t t;
    t = '{rst, fl, v, d, o, chk, ev, ec, er, ed};
    return t;
  endfunction

  vec_t tv[20];
  int   nv[3];
  int   maxc[3];
  bit   done;

  initial begin
    // expectations below are for u0 (DEPTH=2, no pop-through)
    tv[0]  = mk(1, 0, 0, 8'h00, 0, 0, 0, 0, 1, 8'h00);
    tv[1]  = mk(1, 0, 0, 8'h00, 0, 1, 0, 0, 1, 8'h00);
    tv[2]  = mk(0, 0, 1, 8'h0A, 0, 1, 0, 0, 1, 8'h00);
    tv[3]  = mk(0, 0, 1, 8'h0B, 0, 1, 1, 1, 1, 8'h0A);
    tv[4]  = mk(0, 0, 1, 8'h0C, 0, 1, 1, 2, 0, 8'h0A);
    tv[5]  = mk(0, 0, 0, 8'h0C, 1, 1, 1, 2, 0, 8'h0A);
    tv[6]  = mk(0, 0, 0, 8'h0C, 1, 1, 1, 1, 1, 8'h0B);
    tv[7]  = mk(0, 0, 0, 8'h0C, 1, 1, 0, 0, 1, 8'h00);
    tv[8]  = mk(0, 0, 1, 8'h01, 0, 1, 0, 0, 1, 8'h00);
    tv[9]  = mk(0, 0, 1, 8'h02, 0, 1, 1, 1, 1, 8'h01);
    tv[10] = mk(0, 1, 1, 8'h55, 0, 1, 1, 2, 0, 8'h01);
    tv[11] = mk(0, 0, 0, 8'h55, 1, 1, 0, 0, 1, 8'h00);
    tv[12] = mk(0, 0, 0, 8'h00, 0, 1, 0, 0, 1, 8'h00);
    tv[13] = mk(0, 0, 1, 8'h03, 0, 1, 0, 0, 1, 8'h00);
    tv[14] = mk(0, 0, 1, 8'h04, 0, 1, 1, 1, 1, 8'h03);
    tv[15] = mk(1, 1, 1, 8'h09, 0, 1, 1, 2, 0, 8'h03);
    tv[16] = mk(0, 0, 1, 8'h07, 0, 1, 0, 0, 1, 8'h00);
    tv[17] = mk(0, 0, 0, 8'h07, 0, 1, 1, 1, 1, 8'h07);
    tv[18] = mk(0, 0, 0, 8'h07, 1, 1, 1, 1, 1, 8'h07);
    tv[19] = mk(0, 0, 0, 8'h00, 1, 1, 0, 0, 1, 8'h00);

    drive(1, 0, 0, 8'h00, 0);
    @(negedge clk);

    for (int k = 0; k < 20; k++) begin
      drive(tv[k].rst, tv[k].fl, tv[k].v, tv[k].d, tv[k].o);
      #1;
      if (tv[k].chk) begin
        cmp($sformatf("vec%0d_valid", k), 0, ov[0], tv[k].ev);
        cmp($sformatf("vec%0d_count", k), 0, oc[0], tv[k].ec);
        cmp($sformatf("vec%0d_ready", k), 0, ird[0], tv[k].er);
        cmp($sformatf("vec%0d_data", k), 0, od[0], tv[k].ed);
      end
      cycle(tv[k].chk);
    end

    // full pop-through on u1: {1,2} full, push 3 with pop
    drive(0, 0, 1, 8'h01, 0);
    cycle(1);
    drive(0, 0, 1, 8'h02, 0);
    cycle(1);
    drive(0, 0, 1, 8'h03, 1);
    #1;
    cmp("pt_full_count", 1, oc[1], 2);
    cmp("pt_full_ready", 1, ird[1], 1);
    cmp("pt_nopt_ready", 0, ird[0], 0);
    cycle(1);
    drive(0, 0, 0, 8'h03, 0);
    #1;
    cmp("pt_after_count", 1, oc[1], 2);
    cmp("pt_after_data", 1, od[1], 8'h02);
    cycle(1);
    drive(0, 0, 0, 8'h00, 1);
    cycle(1);
    #1;
    cmp("pt_last_data", 1, od[1], 8'h03);
    cmp("pt_last_count", 1, oc[1], 1);
    cycle(1);
    cycle(1);
    cycle(1);

    // stream 0..9 with out_ready toggling 1,0,1,0
    for (int i = 0; i < 3; i++) begin
      popped[i].delete();
      nv[i]   = 0;
      maxc[i] = 0;
    end
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      reset = 1'b0;
      flush = 1'b0;
      for (int i = 0; i < 3; i++) begin
        iv[i]   = (nv[i] < 10);
        id[i]   = 8'(nv[i]);
        ordy[i] = (c % 2 == 0);
      end
      cycle(1);
      done = 1'b1;
      for (int i = 0; i < 3; i++) begin
        if (acc[i]) nv[i]++;
        if (int'(oc[i]) > maxc[i]) maxc[i] = int'(oc[i]);
        if (popped[i].size() < 10) done = 1'b0;
      end
    end
    for (int i = 0; i < 3; i++) begin
      cmp("wrap_n", i, popped[i].size(), 10);
      for (int k = 0; k < 10 && k < popped[i].size(); k++)
        cmp($sformatf("wrap_ord%0d", k), i, popped[i][k], k);
      cmp("wrap_maxc_ok", i, maxc[i] <= dep[i], 1);
    end
    cmp("wrap_d3_fill", 2, maxc[2] >= 2, 1);

    // randomized traffic against the queue model
    for (int i = 0; i < 3; i++) hold[i] = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      flush = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < 3; i++) begin
        if (!hold[i]) begin
          iv[i] = ($urandom_range(0, 2) != 0);
          id[i] = 8'($urandom);
        end
        ordy[i] = ($urandom_range(0, 3) != 0);
      end
      cycle(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
